// File: rtl/agc_pkg.sv
// Constants and FSM state type shared by the AGC gain path and the downstream multiply stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_pkg;

    // Offset-binary zero of the ADC stream; the multiply stage uses it as well.
    localparam logic [7:0] MIDSCALE   = 8'd128;
    // Fractional bits of the gain word, U(GAIN_W-8).8.
    localparam int         GAIN_FRAC  = 8;
    // Gain of 1.0 in that format.
    localparam int         GAIN_UNITY = 1 << GAIN_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } agc_state_t;

endpackage

// File: rtl/agc_restoring_div.sv
// Unsigned 16-bit / 8-bit restoring divider, one quotient bit per clock, MSB first.
// Latency: exactly 16 clocks after i_start; o_done pulses in the cycle after the last step.
// Backpressure: none; a new i_start restarts the divider and discards any division in flight.
//
// Ports: clk/rst_n (synchronous, active-low), i_start loads i_num/i_den,
//        o_quo truncated quotient (valid while o_done), o_run high while steps remain.
//        A zero denominator yields all-ones; callers treat that result as meaningless.
module agc_restoring_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_num,
    input  logic [7:0]  i_den,
    output logic [15:0] o_quo,
    output logic        o_run,
    output logic        o_done
);

    logic [15:0] r_quo;
    logic [7:0]  r_rem;
    logic [7:0]  r_den;
    logic [4:0]  r_cnt;
    logic        r_done;

    logic [8:0]  w_shift;
    logic        w_ge;
    logic [7:0]  w_diff;

    // The remainder is always below the denominator, so 8 bits hold it and the
    // shifted partial remainder needs only one extra bit.
    assign w_shift = {r_rem, r_quo[15]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_diff  = w_shift[7:0] - r_den;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                // Numerator bits are shifted out of the quotient register as
                // quotient bits are shifted in.
                r_quo <= i_num;
                r_rem <= '0;
                r_den <= i_den;
                r_cnt <= 5'd16;
            end else if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
                r_quo <= {r_quo[14:0], w_ge};
                r_rem <= w_ge ? w_diff : w_shift[7:0];
                if (r_cnt == 5'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_quo  = r_quo;
    assign o_run  = (r_cnt != 5'd0);
    assign o_done = r_done;

endmodule

// File: rtl/agc_gain_calc.sv
// Windowed ADC peak detector that converts peak deviation into gain = TARGET*256/(peak-128), saturated.
// Latency: 17 clocks from the edge accepting the window's last sample to the gain_valid cycle.
// Backpressure: none; samples are always accepted, gain_valid is a one-cycle strobe the consumer must latch.
//
// Ports: clkin_50MHz / rst_n (synchronous, active-low); sample_en + ADCin offset-binary sample stream;
//        gain_out U(GAIN_W-8).8, gain_valid strobe, peak_out window peak, no_signal when peak <= midscale,
//        busy while the divider is producing quotient bits.
module agc_gain_calc
    import agc_pkg::*;
#(
    parameter int WIN_LEN = 500,
    parameter int TARGET  = 36,
    parameter int GAIN_W  = 12
) (
    input  logic              clkin_50MHz,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [7:0]        ADCin,
    output logic [GAIN_W-1:0] gain_out,
    output logic              gain_valid,
    output logic [7:0]        peak_out,
    output logic              no_signal,
    output logic              busy
);

    localparam logic [9:0]  LAST_IDX = 10'(WIN_LEN - 1);
    localparam logic [15:0] NUMER    = 16'(TARGET * 256);
    localparam logic [15:0] GAIN_MAX = 16'((1 << GAIN_W) - 1);

    agc_state_t        r_state;
    agc_state_t        w_next;

    logic [9:0]        r_cnt;
    logic [7:0]        r_peak;
    logic [7:0]        r_snap;
    logic              r_busy;
    logic [GAIN_W-1:0] r_gain;
    logic [7:0]        r_peak_out;
    logic              r_no_sig;
    logic              r_valid;

    logic [7:0]        w_peak_nxt;
    logic              w_close;
    logic [7:0]        w_den;
    logic              w_start;
    logic              w_publish;
    logic              w_sat;
    logic [GAIN_W-1:0] w_gain;
    logic [15:0]       w_quo;
    logic              w_div_run;
    logic              w_div_done;

    // First sample of a window replaces the peak outright so a previous
    // window's maximum can never leak forward.
    assign w_peak_nxt = ((r_cnt == 10'd0) || (ADCin >= r_peak)) ? ADCin : r_peak;
    assign w_close    = sample_en && (r_cnt == LAST_IDX);
    assign w_den      = (w_peak_nxt > MIDSCALE) ? (w_peak_nxt - MIDSCALE) : 8'd0;

    always_ff @(posedge clkin_50MHz) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_peak <= MIDSCALE;
            r_snap <= MIDSCALE;
        end else begin
            if (sample_en) begin
                r_peak <= w_peak_nxt;
                r_cnt  <= w_close ? 10'd0 : (r_cnt + 10'd1);
            end
            // A close arriving while a division is in flight is dropped.
            if (w_start) begin
                r_snap <= w_peak_nxt;
            end
        end
    end

    always_ff @(posedge clkin_50MHz) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_close) begin
                    w_start = 1'b1;
                    w_next  = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_publish = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    agc_restoring_div u_div (
        .clk     (clkin_50MHz),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_num   (NUMER),
        .i_den   (w_den),
        .o_quo   (w_quo),
        .o_run   (w_div_run),
        .o_done  (w_div_done)
    );

    // Zero deviation means the quotient is garbage; treat it like overflow.
    assign w_sat  = (r_snap <= MIDSCALE) || (w_quo > GAIN_MAX);
    assign w_gain = w_sat ? GAIN_MAX[GAIN_W-1:0] : w_quo[GAIN_W-1:0];

    always_ff @(posedge clkin_50MHz) begin
        if (!rst_n) begin
            r_gain     <= GAIN_W'(GAIN_UNITY);
            r_peak_out <= MIDSCALE;
            r_no_sig   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= w_publish;
            // Registered copy of the divider's step activity: high for the 16
            // cycles following the load edge.
            r_busy  <= w_div_run;
            if (w_publish) begin
                r_gain     <= w_gain;
                r_peak_out <= r_snap;
                r_no_sig   <= (r_snap <= MIDSCALE);
            end
        end
    end

    assign gain_out   = r_gain;
    assign gain_valid = r_valid;
    assign peak_out   = r_peak_out;
    assign no_signal  = r_no_sig;
    assign busy       = r_busy;

    a_close_only_in_idle: assert property (
        @(posedge clkin_50MHz) disable iff (!rst_n) w_close |-> (r_state == IDLE)
    );

endmodule

// File: tb/tb_agc_gain_calc.sv
// Bench for agc_gain_calc: a 500-sample instance and a 16-sample instance checked against a window-max/divide model.
// Latency: n/a.
// Backpressure: n/a.
module tb_agc_gain_calc;

    localparam int GW      = 12;
    localparam int NUMER   = 36 * 256;
    localparam int GMAX    = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sen   [2];
    logic [7:0]    adc   [2];
    logic [GW-1:0] gout  [2];
    logic          gval  [2];
    logic [7:0]    pout  [2];
    logic          nsig  [2];
    logic          bsy   [2];

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    agc_gain_calc #(.WIN_LEN(500), .TARGET(36), .GAIN_W(GW)) u_dut500 (
        .clkin_50MHz (clk),
        .rst_n       (rst_n),
        .sample_en   (sen[0]),
        .ADCin       (adc[0]),
        .gain_out    (gout[0]),
        .gain_valid  (gval[0]),
        .peak_out    (pout[0]),
        .no_signal   (nsig[0]),
        .busy        (bsy[0])
    );

    agc_gain_calc #(.WIN_LEN(16), .TARGET(36), .GAIN_W(GW)) u_dut16 (
        .clkin_50MHz (clk),
        .rst_n       (rst_n),
        .sample_en   (sen[1]),
        .ADCin       (adc[1]),
        .gain_out    (gout[1]),
        .gain_valid  (gval[1]),
        .peak_out    (pout[1]),
        .no_signal   (nsig[1]),
        .busy        (bsy[1])
    );

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d expected=%0d", nm, idx, act, exp);
        end
    endtask

    function automatic int wl(input int i);
        return (i == 0) ? 500 : 16;
    endfunction

    function automatic int model_gain(input int pk);
        int d;
        int q;
        d = (pk > 128) ? (pk - 128) : 0;
        if (d == 0) return GMAX;
        q = NUMER / d;
        return (q > GMAX) ? GMAX : q;
    endfunction

    // ---------------- reference model ----------------
    int  cyc = 0;
    bit  started = 1'b0;
    int  wbuf [2][512];
    int  wcnt [2];
    int  close_cyc [2];
    int  pend_gain [2];
    int  pend_peak [2];
    int  pend_ns   [2];
    int  e_gain [2];
    int  e_peak [2];
    int  e_ns   [2];

    always @(posedge clk) begin
        int mx;
        cyc++;
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                wcnt[i]      = 0;
                close_cyc[i] = -100;
                e_gain[i]    = 256;
                e_peak[i]    = 128;
                e_ns[i]      = 0;
            end else begin
                if (cyc == close_cyc[i] + 17) begin
                    e_gain[i] = pend_gain[i];
                    e_peak[i] = pend_peak[i];
                    e_ns[i]   = pend_ns[i];
                end
                if (sen[i]) begin
                    wbuf[i][wcnt[i]] = int'(adc[i]);
                    wcnt[i]++;
                    if (wcnt[i] == wl(i)) begin
                        mx = 0;
                        for (int k = 0; k < wl(i); k++) begin
                            if (wbuf[i][k] > mx) mx = wbuf[i][k];
                        end
                        pend_peak[i] = mx;
                        pend_gain[i] = model_gain(mx);
                        pend_ns[i]   = (mx <= 128) ? 1 : 0;
                        close_cyc[i] = cyc;
                        wcnt[i]      = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int dt;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                dt = cyc - close_cyc[i];
                chk("valid", i, int'(gval[i]), (dt == 17) ? 1 : 0);
                chk("busy",  i, int'(bsy[i]),  (dt >= 1 && dt <= 16) ? 1 : 0);
                chk("gain",  i, int'(gout[i]), e_gain[i]);
                chk("peak",  i, int'(pout[i]), e_peak[i]);
                chk("nosig", i, int'(nsig[i]), e_ns[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [7:0] smp(input int kind, input int n);
        int v;
        case (kind)
            0: v = 128 + $rtoi(36.0 * $sin(2.0 * 3.14159265358979 * n / 40.0) + 36.5) - 36;
            1: v = n % 256;
            2: v = n % 130;
            3: v = 128;
            4: v = 100;
            5: v = 150;
            6: v = 200;
            8: v = (n == 5) ? 250 : int'($urandom_range(0, 255));
            9: v = 140;
            default: v = int'($urandom_range(0, 255));
        endcase
        return 8'(v);
    endfunction

    // gap < 0: random 0..7 idle clocks, at least 2 after the first sample of a window
    task automatic run_window(input int i, input int kind, input int len, input int gap);
        int g;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            sen[i] = 1'b1;
            adc[i] = smp(kind, n);
            if (gap < 0) g = (n == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 7));
            else         g = gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                sen[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_valid(input int i);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (gval[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", i, 0, 1);
    endtask

    task automatic expect_out(input int i, input int g, input int p, input int ns);
        chk("lit_gain",  i, int'(gout[i]), g);
        chk("lit_peak",  i, int'(pout[i]), p);
        chk("lit_nosig", i, int'(nsig[i]), ns);
    endtask

    initial begin
        rst_n  = 1'b0;
        sen[0] = 1'b0;
        sen[1] = 1'b0;
        adc[0] = 8'd128;
        adc[1] = 8'd128;
        repeat (3) @(negedge clk);
        expect_out(0, 256, 128, 0);
        chk("lit_rst_valid", 0, int'(gval[0]), 0);
        chk("lit_rst_busy",  0, int'(bsy[0]), 0);
        rst_n = 1'b1;

        // 16-sample windows with random gaps and data; window 3 holds a 250
        // spike, window 4 is flat 140 and must not inherit that spike.
        for (int w = 0; w < 8; w++) begin
            run_window(1, (w == 3) ? 8 : ((w == 4) ? 9 : 7), 16, -1);
            if (w == 4) begin
                wait_valid(1);
                expect_out(1, 768, 140, 0);
            end
        end
        @(negedge clk);
        sen[1] = 1'b0;
        repeat (30) @(negedge clk);

        // 500-sample windows, sample_en every second clock
        run_window(0, 0, 500, 1);  wait_valid(0);  expect_out(0, 256, 164, 0);
        run_window(0, 1, 500, 1);  wait_valid(0);  expect_out(0, 72, 255, 0);
        run_window(0, 2, 500, 1);  wait_valid(0);  expect_out(0, 4095, 129, 0);
        run_window(0, 3, 500, 1);  wait_valid(0);  expect_out(0, 4095, 128, 1);
        run_window(0, 4, 500, 1);  wait_valid(0);  expect_out(0, 4095, 100, 1);

        // Reset pulse at T+8 of a running division
        run_window(0, 5, 500, 1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_out(0, 256, 128, 0);
        chk("lit_abort_busy", 0, int'(bsy[0]), 0);
        repeat (30) @(negedge clk);
        run_window(0, 6, 500, 1);  wait_valid(0);  expect_out(0, 128, 200, 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
